sram_1r1w_march_bist: RTL and testbench
=======================================

// Module: sram_1r1w_march_bist
// PURPOSE
//  Built-in self-test initiator for the 1r1w SRAM wrappers (sram_1r1w_*): drives the read and write ports and checks read data.
//  Runs March C- (6 elements) over every address, captures the first miscompare and reports pass/fail.
//  Sits beside each cache/tag SRAM; the parent muxes mem_* onto the SRAM while bist_active=1.
// PARAMETERS
//  DATA_WIDTH  20            word width of target SRAM
//  SIZE        64            number of words; need not be a power of two (e.g. 52)
//  ADDR_WIDTH  $clog2(SIZE)  address width
// PORTS
//  clk             in   1           clock, all flops rising-edge
//  reset_n         in   1           asynchronous reset, active-low
//  start           in   1           1-cycle request; sampled only in IDLE/DONE
//  bist_active     out  1           test running; parent selects BIST onto SRAM
//  done            out  1           test complete; held until next accepted start
//  fail            out  1           sticky miscompare flag; valid when done=1
//  fail_addr       out  ADDR_WIDTH  address of first miscompare
//  fail_bits       out  DATA_WIDTH  expected XOR actual at first miscompare
//  mem_read_en     out  1           to SRAM read_en
//  mem_read_addr   out  ADDR_WIDTH  to SRAM read_addr
//  mem_read_data   in   DATA_WIDTH  from SRAM read_data; valid the cycle after mem_read_en
//  mem_write_en    out  1           to SRAM write_en
//  mem_write_addr  out  ADDR_WIDTH  to SRAM write_addr
//  mem_write_data  out  DATA_WIDTH  to SRAM write_data
// BEHAVIOUR
//  - Reset: every output 0. State IDLE. Reset takes effect asynchronously, including mid-test; mem enables drop immediately.
//  - All outputs are driven from flops.
//  - SRAM read latency is 1 cycle: read issued in cycle t, data compared at the edge ending cycle t+1.
//  - States: IDLE -> W0_UP -> R0W1_UP -> R1W0_UP -> R0W1_DN -> R1W0_DN -> R0_UP -> DONE.
//  - start in IDLE or DONE: clear done/fail/fail_addr/fail_bits and go to W0_UP. start in any other state is ignored.
//  - bist_active=1 in every state except IDLE and DONE.
//  - Patterns: "0" = all-zeros word; "1" = all-ones word.
//  - UP elements use addresses 0..SIZE-1; DN elements use SIZE-1..0. The counter never leaves this range.
//  - W0_UP: write 0 to one address per cycle. Lasts SIZE cycles; no reads.
//  - RxWy elements are pipelined and last SIZE+1 cycles:
//    - cycle 0: read A0.
//    - cycle k (1..SIZE-1): compare A(k-1) against x, write y to A(k-1), read A(k).
//    - cycle SIZE: compare and write the last address; no read.
//  - Read and write addresses are never equal in the same cycle, so READ_DURING_WRITE has no effect.
//  - R0_UP: read/compare 0 only. Lasts SIZE+1 cycles.
//  - Total: 6*SIZE+5 active cycles. done=1 and bist_active=0 exactly 6*SIZE+5 edges after the edge that samples start.
//  - Miscompare: set fail. On the first miscompare only, load fail_addr and fail_bits. The test always runs to completion.
//  - DONE holds all results. A new start restarts the test.
// STRUCTURE
//  - Package sram_bist_pkg holds:
//    - typedef enum bist_state_t (the 8 states above).
//    - per-element descriptor: read_expected, write_value, direction, has_read, has_write.
//    - localparam NUM_ELEMENTS=6.
//  - Sub-module sram_bist_addr_gen: up/down address counter.
//    - Inputs: load/step/direction. Outputs: addr, last flag.
//    - Handles SIZE-1 <-> 0 terminal values for non-power-of-two SIZE.
// TESTING (bench: behavioural 1r1w model with fault injection; DATA_WIDTH=4, SIZE=8 unless noted)
//  1. Fault-free: start pulse -> done rises exactly 53 edges later. fail=0, fail_addr=0, fail_bits=0.
//  2. Stuck-at-1 bit2 @addr5 -> fail=1, fail_addr=5, fail_bits=4'b0100.
//     Detected in R0W1_UP; later miscompares do not overwrite the captured values.
//  3. Stuck-at-0 bit0 @addr0 -> fail=1, fail_addr=0, fail_bits=4'b0001 (detected in R1W0_UP).
//  4. Protocol monitor, every run:
//     - R0W1_DN/R1W0_DN writes go 7..0.
//     - No same-address read+write in one cycle.
//     - mem_* are all 0 whenever bist_active=0.
//  5. reset_n low mid R1W0_UP -> all outputs 0 without waiting for a clock.
//     Then release reset and start -> clean pass in 53 cycles.
//  6. Extra start pulses while busy are ignored (same 53-cycle completion).
//     start from DONE after a failed run clears fail before rerun.
//     SIZE=52, DATA_WIDTH=16: addresses stay within 0..51; done after 317 edges.

Source files
------------

// File: rtl/sram_bist_pkg.sv
// Shared types for the 1r1w SRAM March C- BIST: sequencer states, per-element
// descriptors and the element ordering.
package sram_bist_pkg;

  localparam int NUM_ELEMENTS = 6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_W0_UP   = 3'd1,
    ST_R0W1_UP = 3'd2,
    ST_R1W0_UP = 3'd3,
    ST_R0W1_DN = 3'd4,
    ST_R1W0_DN = 3'd5,
    ST_R0_UP   = 3'd6,
    ST_DONE    = 3'd7
  } bist_state_t;

  // direction: 1 walks SIZE-1 down to 0
  typedef struct packed {
    logic read_expected;
    logic write_value;
    logic direction;
    logic has_read;
    logic has_write;
  } element_desc_t;

  function automatic element_desc_t element_desc(input bist_state_t st);
    element_desc_t d;
    case (st)
      ST_W0_UP:   d = '{read_expected: 1'b0, write_value: 1'b0, direction: 1'b0, has_read: 1'b0, has_write: 1'b1};
      ST_R0W1_UP: d = '{read_expected: 1'b0, write_value: 1'b1, direction: 1'b0, has_read: 1'b1, has_write: 1'b1};
      ST_R1W0_UP: d = '{read_expected: 1'b1, write_value: 1'b0, direction: 1'b0, has_read: 1'b1, has_write: 1'b1};
      ST_R0W1_DN: d = '{read_expected: 1'b0, write_value: 1'b1, direction: 1'b1, has_read: 1'b1, has_write: 1'b1};
      ST_R1W0_DN: d = '{read_expected: 1'b1, write_value: 1'b0, direction: 1'b1, has_read: 1'b1, has_write: 1'b1};
      ST_R0_UP:   d = '{read_expected: 1'b0, write_value: 1'b0, direction: 1'b0, has_read: 1'b1, has_write: 1'b0};
      default:    d = '{read_expected: 1'b0, write_value: 1'b0, direction: 1'b0, has_read: 1'b0, has_write: 1'b0};
    endcase
    return d;
  endfunction

  function automatic bist_state_t next_element(input bist_state_t st);
    bist_state_t n;
    case (st)
      ST_W0_UP:   n = ST_R0W1_UP;
      ST_R0W1_UP: n = ST_R1W0_UP;
      ST_R1W0_UP: n = ST_R0W1_DN;
      ST_R0W1_DN: n = ST_R1W0_DN;
      ST_R1W0_DN: n = ST_R0_UP;
      ST_R0_UP:   n = ST_DONE;
      default:    n = ST_IDLE;
    endcase
    return n;
  endfunction

  function automatic logic is_active(input bist_state_t st);
    return (st != ST_IDLE) && (st != ST_DONE);
  endfunction

  // One W0 element of SIZE cycles plus five read elements of SIZE+1 cycles.
  function automatic int active_cycles(input int size);
    return NUM_ELEMENTS * size + NUM_ELEMENTS - 1;
  endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// Up/down address pointer for the March sequencer. Saturates at 0 and SIZE-1,
// so a non-power-of-two SIZE never produces an out-of-range address.
module sram_bist_addr_gen #(
  parameter int SIZE       = 64,
  parameter int ADDR_WIDTH = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic                  step,
  input  logic                  direction,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] TOP_ADDR = ADDR_WIDTH'(SIZE - 1);

  logic [ADDR_WIDTH-1:0] addr_next_s;

  // Next pointer value: load picks the first address of the direction
  always_comb begin
    addr_next_s = addr;
    if (load) begin
      addr_next_s = direction ? TOP_ADDR : '0;
    end else if (step) begin
      if (direction) begin
        addr_next_s = (addr == '0) ? '0 : addr - 1'b1;
      end else begin
        addr_next_s = (addr == TOP_ADDR) ? TOP_ADDR : addr + 1'b1;
      end
    end else begin
      addr_next_s = addr;
    end
  end

  // Pointer and terminal flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr <= '0;
      last <= 1'b0;
    end else begin
      addr <= addr_next_s;
      last <= direction ? (addr_next_s == '0) : (addr_next_s == TOP_ADDR);
    end
  end

endmodule

// File: rtl/sram_1r1w_march_bist.sv
// March C- BIST initiator for a 1r1w SRAM with 1-cycle read latency. Every
// edge "issues" one bus cycle into the mem_* flops; read data is compared one
// cycle after the read and the first miscompare is captured.
module sram_1r1w_march_bist
  import sram_bist_pkg::*;
#(
  parameter int DATA_WIDTH = 20,
  parameter int SIZE       = 64,
  parameter int ADDR_WIDTH = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  bist_active,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_bits,
  output logic                  mem_read_en,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data
);

  bist_state_t           state_r;
  bist_state_t           state_next_s;
  bist_state_t           issue_state_s;
  element_desc_t         desc_s;
  element_desc_t         next_desc_s;
  logic                  accept_start_s;

  logic                  tail_r;
  logic                  have_prev_r;
  logic [ADDR_WIDTH-1:0] prev_addr_r;
  logic                  tail_next_s;
  logic                  have_prev_next_s;
  logic [ADDR_WIDTH-1:0] prev_addr_next_s;
  logic                  element_end_s;

  logic                  gen_load_s;
  logic                  gen_step_s;
  logic                  gen_dir_s;
  logic [ADDR_WIDTH-1:0] gen_addr_s;
  logic                  gen_last_s;

  logic                  read_en_s;
  logic [ADDR_WIDTH-1:0] read_addr_s;
  logic                  write_en_s;
  logic [ADDR_WIDTH-1:0] write_addr_s;
  logic                  write_one_s;

  logic                  read_one_r;
  logic                  pend_r;
  logic                  pend_one_r;
  logic [ADDR_WIDTH-1:0] pend_addr_r;
  logic [DATA_WIDTH-1:0] diff_s;
  logic                  miscompare_s;

  sram_bist_addr_gen #(
    .SIZE       (SIZE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (gen_load_s),
    .step      (gen_step_s),
    .direction (gen_dir_s),
    .addr      (gen_addr_s),
    .last      (gen_last_s)
  );

  // An accepted start issues the first W0 cycle on the same edge
  assign accept_start_s = start && !is_active(state_r);
  assign issue_state_s  = accept_start_s ? ST_W0_UP : state_r;
  assign desc_s         = element_desc(issue_state_s);
  assign next_desc_s    = element_desc(next_element(issue_state_s));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state: advance to the next element after its final issued cycle
  always_comb begin
    state_next_s = state_r;
    if (is_active(issue_state_s)) begin
      state_next_s = element_end_s ? next_element(issue_state_s) : issue_state_s;
    end else begin
      state_next_s = state_r;
    end
  end

  // Issue decode: SRAM port values for the next cycle and pointer movement
  always_comb begin
    read_en_s        = 1'b0;
    read_addr_s      = '0;
    write_en_s       = 1'b0;
    write_addr_s     = '0;
    write_one_s      = 1'b0;
    tail_next_s      = 1'b0;
    have_prev_next_s = 1'b0;
    prev_addr_next_s = '0;
    element_end_s    = 1'b0;
    gen_load_s       = 1'b0;
    gen_step_s       = 1'b0;
    gen_dir_s        = desc_s.direction;
    if (!is_active(issue_state_s)) begin
      gen_dir_s = 1'b0;
    end else if (!desc_s.has_read) begin
      write_en_s   = 1'b1;
      write_addr_s = gen_addr_s;
      write_one_s  = desc_s.write_value;
      if (gen_last_s) begin
        element_end_s = 1'b1;
        gen_load_s    = 1'b1;
        gen_dir_s     = next_desc_s.direction;
      end else begin
        gen_step_s = 1'b1;
      end
    end else if (tail_r) begin
      // Final cycle of a read element: write back the last address, no read
      write_en_s    = desc_s.has_write;
      write_addr_s  = desc_s.has_write ? prev_addr_r : '0;
      write_one_s   = desc_s.has_write & desc_s.write_value;
      element_end_s = 1'b1;
      gen_load_s    = 1'b1;
      gen_dir_s     = next_desc_s.direction;
    end else begin
      read_en_s        = 1'b1;
      read_addr_s      = gen_addr_s;
      write_en_s       = desc_s.has_write & have_prev_r;
      write_addr_s     = (desc_s.has_write & have_prev_r) ? prev_addr_r : '0;
      write_one_s      = desc_s.has_write & have_prev_r & desc_s.write_value;
      have_prev_next_s = 1'b1;
      prev_addr_next_s = gen_addr_s;
      if (gen_last_s) begin
        tail_next_s = 1'b1;
      end else begin
        gen_step_s = 1'b1;
      end
    end
  end

  // Element pipeline bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tail_r      <= 1'b0;
      have_prev_r <= 1'b0;
      prev_addr_r <= '0;
    end else begin
      tail_r      <= tail_next_s;
      have_prev_r <= have_prev_next_s;
      prev_addr_r <= prev_addr_next_s;
    end
  end

  // Registered SRAM port drive and status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bist_active    <= 1'b0;
      done           <= 1'b0;
      mem_read_en    <= 1'b0;
      mem_read_addr  <= '0;
      mem_write_en   <= 1'b0;
      mem_write_addr <= '0;
      mem_write_data <= '0;
      read_one_r     <= 1'b0;
    end else begin
      bist_active    <= is_active(issue_state_s);
      done           <= (issue_state_s == ST_DONE);
      mem_read_en    <= read_en_s;
      mem_read_addr  <= read_addr_s;
      mem_write_en   <= write_en_s;
      mem_write_addr <= write_addr_s;
      mem_write_data <= {DATA_WIDTH{write_one_s}};
      read_one_r     <= read_en_s & desc_s.read_expected;
    end
  end

  // Read data arrives one cycle after mem_read_en; track what it should be
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_r      <= 1'b0;
      pend_one_r  <= 1'b0;
      pend_addr_r <= '0;
    end else begin
      pend_r      <= mem_read_en;
      pend_one_r  <= read_one_r;
      pend_addr_r <= mem_read_addr;
    end
  end

  assign diff_s       = mem_read_data ^ {DATA_WIDTH{pend_one_r}};
  assign miscompare_s = pend_r && (diff_s != '0);

  // Sticky fail flag; address/bit pattern captured on the first miscompare only
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_bits <= '0;
    end else if (accept_start_s) begin
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_bits <= '0;
    end else if (miscompare_s) begin
      fail <= 1'b1;
      if (!fail) begin
        fail_addr <= pend_addr_r;
        fail_bits <= diff_s;
      end else begin
        fail_addr <= fail_addr;
        fail_bits <= fail_bits;
      end
    end else begin
      fail      <= fail;
      fail_addr <= fail_addr;
      fail_bits <= fail_bits;
    end
  end

endmodule

// File: tb/tb_sram_1r1w_march_bist.sv
// Directed bench for the March C- BIST: behavioural 1r1w SRAMs with read-side
// stuck-at faults, a bus protocol monitor and per-scenario checks.
module tb_sram_1r1w_march_bist;

  localparam int DW  = 4;
  localparam int SZ  = 8;
  localparam int AW  = 3;
  localparam int DW2 = 16;
  localparam int SZ2 = 52;
  localparam int AW2 = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic start, start2;

  logic          bist_active, done, fail;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_bits;
  logic          mem_read_en, mem_write_en;
  logic [AW-1:0] mem_read_addr, mem_write_addr;
  logic [DW-1:0] mem_read_data = '0;
  logic [DW-1:0] mem_write_data;

  logic           bist_active2, done2, fail2;
  logic [AW2-1:0] fail_addr2;
  logic [DW2-1:0] fail_bits2;
  logic           mem_read_en2, mem_write_en2;
  logic [AW2-1:0] mem_read_addr2, mem_write_addr2;
  logic [DW2-1:0] mem_read_data2 = '0;
  logic [DW2-1:0] mem_write_data2;

  int checks = 0;
  int errors = 0;

  logic          fault_en = 1'b0;
  logic [AW-1:0] fault_addr = '0;
  logic [DW-1:0] fault_set = '0;
  logic [DW-1:0] fault_clr = '0;

  logic [DW-1:0]    mem  [SZ];
  logic [DW2-1:0]   mem2 [SZ2];
  logic [AW+DW-1:0] wq[$];
  int               max_addr2 = 0;

  sram_1r1w_march_bist #(.DATA_WIDTH(DW), .SIZE(SZ), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .bist_active(bist_active), .done(done),
    .fail(fail), .fail_addr(fail_addr), .fail_bits(fail_bits),
    .mem_read_en(mem_read_en), .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
    .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data)
  );

  sram_1r1w_march_bist #(.DATA_WIDTH(DW2), .SIZE(SZ2), .ADDR_WIDTH(AW2)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .bist_active(bist_active2), .done(done2),
    .fail(fail2), .fail_addr(fail_addr2), .fail_bits(fail_bits2),
    .mem_read_en(mem_read_en2), .mem_read_addr(mem_read_addr2), .mem_read_data(mem_read_data2),
    .mem_write_en(mem_write_en2), .mem_write_addr(mem_write_addr2), .mem_write_data(mem_write_data2)
  );

  function automatic logic [DW-1:0] faulty(input logic [DW-1:0] d, input logic [AW-1:0] a);
    if (fault_en && a == fault_addr) return (d | fault_set) & ~fault_clr;
    else return d;
  endfunction

  // SRAM models: 1-cycle registered read
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_write_addr] <= mem_write_data;
    if (mem_read_en) mem_read_data <= faulty(mem[mem_read_addr], mem_read_addr);
    if (mem_write_en2 && int'(mem_write_addr2) < SZ2) mem2[mem_write_addr2] <= mem_write_data2;
    if (mem_read_en2 && int'(mem_read_addr2) < SZ2) mem_read_data2 <= mem2[mem_read_addr2];
  end

  // Protocol monitor
  always @(negedge clk) begin
    if (reset_n) begin
      if (!bist_active) begin
        checks++;
        if ({mem_read_en, mem_read_addr, mem_write_en, mem_write_addr, mem_write_data} !== '0) begin
          errors++;
          $display("FAIL idle_bus: mem_* = %b, expected all zero", {mem_read_en, mem_read_addr, mem_write_en, mem_write_addr, mem_write_data});
        end
      end else begin
        if (mem_read_en && mem_write_en) begin
          checks++;
          if (mem_read_addr == mem_write_addr) begin
            errors++;
            $display("FAIL same_addr_rw: read and write both at %0d", mem_read_addr);
          end
        end
        if (mem_write_en) wq.push_back({mem_write_addr, mem_write_data});
      end
      if (mem_read_en2 || mem_write_en2) begin
        checks++;
        if (int'(mem_read_addr2) >= SZ2 || int'(mem_write_addr2) >= SZ2) begin
          errors++;
          $display("FAIL addr_range52: rd %0d wr %0d, expected < 52", mem_read_addr2, mem_write_addr2);
        end
        if (mem_read_en2 && int'(mem_read_addr2) > max_addr2) max_addr2 = int'(mem_read_addr2);
      end
    end
  end

  task automatic run1(input bit noisy, output int edges, output logic flags_after_start);
    int bad;
    int e;
    int j;
    logic [AW+DW-1:0] exp_w;
    wq.delete();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flags_after_start = fail | done;
    edges = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        edges = n;
        break;
      end
      if (noisy && (n == 2 || n == 19 || n == 51)) start = 1'b1;
    end
    checks++;
    if (edges != 53) begin
      errors++;
      $display("FAIL done_latency: got %0d edges, expected 53", edges);
    end
    bad = -1;
    if (wq.size() != 40) bad = 999;
    for (int i = 0; i < 40 && i < wq.size(); i++) begin
      e = i / 8;
      j = i % 8;
      exp_w = {3'((e >= 3) ? (7 - j) : j), ((e == 1 || e == 3) ? 4'hF : 4'h0)};
      if (wq[i] !== exp_w && bad < 0) bad = i;
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL write_order: first bad write index %0d of %0d writes, expected 40 in March order", bad, wq.size());
    end
  endtask

  task automatic check_result(input string name, input logic ef, input logic [AW-1:0] ea, input logic [DW-1:0] eb);
    checks++;
    if ({fail, fail_addr, fail_bits} !== {ef, ea, eb}) begin
      errors++;
      $display("FAIL %s: fail=%b addr=%0d bits=%b, expected fail=%b addr=%0d bits=%b", name, fail, fail_addr, fail_bits, ef, ea, eb);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0;
    start2 = 1'b0;
    #3;
    checks++;
    if ({bist_active, done, fail, fail_addr, fail_bits, mem_read_en, mem_read_addr, mem_write_en, mem_write_addr, mem_write_data,
         bist_active2, done2, fail2, mem_read_en2, mem_write_en2} !== '0) begin
      errors++;
      $display("FAIL reset_state: some output nonzero in reset, expected all zero");
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_fault_free();
    int edges;
    logic f;
    fault_en = 1'b0;
    run1(1'b0, edges, f);
    check_result("fault_free", 1'b0, 3'd0, 4'b0000);
  endtask

  task automatic test_stuck_at1();
    int edges;
    logic f;
    fault_en = 1'b1;
    fault_addr = 3'd5;
    fault_set = 4'b0100;
    fault_clr = 4'b0000;
    run1(1'b0, edges, f);
    check_result("stuck_at1_bit2_addr5", 1'b1, 3'd5, 4'b0100);
  endtask

  task automatic test_restart_after_fail();
    int edges;
    logic f;
    fault_en = 1'b0;
    run1(1'b0, edges, f);
    checks++;
    if (f !== 1'b0) begin
      errors++;
      $display("FAIL restart_clear: fail|done=%b after start, expected 0", f);
    end
    check_result("restart_pass", 1'b0, 3'd0, 4'b0000);
  endtask

  task automatic test_stuck_at0();
    int edges;
    logic f;
    fault_en = 1'b1;
    fault_addr = 3'd0;
    fault_set = 4'b0000;
    fault_clr = 4'b0001;
    run1(1'b0, edges, f);
    check_result("stuck_at0_bit0_addr0", 1'b1, 3'd0, 4'b0001);
  endtask

  task automatic test_reset_mid_run();
    int edges;
    logic f;
    fault_en = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (bist_active !== 1'b1) begin
      errors++;
      $display("FAIL mid_run_active: bist_active=%b, expected 1", bist_active);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bist_active, done, fail, fail_addr, fail_bits, mem_read_en, mem_read_addr, mem_write_en, mem_write_addr, mem_write_data} !== '0) begin
      errors++;
      $display("FAIL async_reset: outputs=%b, expected all zero", {bist_active, done, fail, mem_read_en, mem_write_en});
    end
    @(negedge clk);
    reset_n = 1'b1;
    run1(1'b0, edges, f);
    check_result("after_reset_pass", 1'b0, 3'd0, 4'b0000);
  endtask

  task automatic test_busy_start();
    int edges;
    logic f;
    fault_en = 1'b0;
    run1(1'b1, edges, f);
    check_result("busy_start_pass", 1'b0, 3'd0, 4'b0000);
  endtask

  task automatic test_size52();
    int edges;
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    edges = -1;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk);
      #1;
      if (done2) begin
        edges = n;
        break;
      end
    end
    checks++;
    if (edges != 317) begin
      errors++;
      $display("FAIL size52_latency: got %0d edges, expected 317", edges);
    end
    checks++;
    if ({fail2, fail_addr2, fail_bits2} !== '0) begin
      errors++;
      $display("FAIL size52_result: fail=%b addr=%0d bits=%h, expected 0", fail2, fail_addr2, fail_bits2);
    end
    checks++;
    if (max_addr2 != 51) begin
      errors++;
      $display("FAIL size52_max_addr: got %0d, expected 51", max_addr2);
    end
  endtask

  initial begin
    test_reset();
    test_fault_free();
    test_stuck_at1();
    test_restart_after_fail();
    test_stuck_at0();
    test_reset_mid_run();
    test_busy_start();
    test_size52();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
